// File: rtl/cpu_press_gen.sv
// cpu_press_gen: LFSR-driven computer-player press generator with a saturating press counter.
// Optional post-press lockout is enabled by defining CPU_PRESS_HOLDOFF_EN.
module cpu_press_gen #(
    parameter int             WIDTH   = 9,
    parameter logic [WIDTH:0] TAPS    = 'h240,
    parameter logic [WIDTH:0] SEED    = 'h001,
    parameter int             HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] SW,
    output logic             press,
    output logic [WIDTH:0]   rnd,
    output logic [7:0]       press_cnt
);
    logic [WIDTH:0] lfsr_q;
    logic           hit;
    logic           fire;

    assign rnd = lfsr_q;
    // top LFSR bit gates the compare, roughly halving the press rate at any SW
    assign hit = !lfsr_q[WIDTH] && (SW > lfsr_q[WIDTH-1:0]);

`ifdef CPU_PRESS_HOLDOFF_EN
    logic [7:0] hold_q;

    assign fire = hit && enable && hold_q == 8'd0;

    always_ff @(posedge clk) begin
        if (reset)
            hold_q <= 8'd0;
        else if (fire)
            hold_q <= 8'(HOLDOFF);
        else if (hold_q != 8'd0)
            hold_q <= hold_q - 8'd1;
    end
`else
    assign fire = hit && enable;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q    <= SEED;
            press     <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            if (lfsr_q == '0)
                lfsr_q <= SEED;
            else if (enable)
                lfsr_q <= {lfsr_q[WIDTH-1:0], ^(lfsr_q & TAPS)};
            press <= fire;
            if (fire && press_cnt != 8'hFF)
                press_cnt <= press_cnt + 8'd1;
        end
    end
endmodule
